shiftl_seq: RTL and testbench

Sequential logical shift-left unit for the ALU datapath. It is the left-direction counterpart of the combinational right shifter. The block shifts one bit position per clock under a start/done handshake and produces the same C/N/V/Z flag set as the other ALU operations. Its purpose is to keep shift-left area small for wide M, at the cost of variable latency.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/mux_2NtoN.sv | 14 +
 rtl/shiftl_seq.sv | 148 ++++++++++++++
 tb/tb_shiftl_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: sequencer state encoding and the common C/N/V/Z flag bundle.
package alu_pkg;

    // Sequential shift-left control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shiftl_state_t;

    // Flag set produced by every ALU operation.
    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } alu_flags_t;

    // Flags matching a zero result after reset.
    localparam alu_flags_t FLAGS_RST = 4'b0001;

endpackage

// File: rtl/mux_2NtoN.sv
// Two-way M-bit word multiplexer: sel=1 picks b, sel=0 picks a.
module mux_2NtoN #(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         sel,
    output logic [M-1:0] y_c
);

    // Pure combinational select.
    assign y_c = sel ? b : a;

endmodule

// File: rtl/shiftl_seq.sv
// Sequential logical shift-left, one bit per clock, with start/done handshake
// and the standard ALU flag set. Out-of-range amounts saturate to M shifts.
module shiftl_seq
    import alu_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z
);

    localparam int unsigned CW = $clog2(M + 1);

    shiftl_state_t state_q, state_nxt;
    logic [M-1:0]  work_q, work_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          carry_q, carry_nxt;
    logic          vlat_q, vlat_nxt;
    logic [M-1:0]  r_q, r_nxt;
    alu_flags_t    flags_q, flags_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;

    logic [M-1:0]  shifted_c;
    logic [M-1:0]  mux_y_c;
    logic          load_c;
    logic          b_big_c;

    // Working value shifted by one, zero fill.
    assign shifted_c = {work_q[M-2:0], 1'b0};

    // Outside SHIFT the mux presents the operand for loading.
    assign load_c = (state_q != SHIFT);

    // Full-width range test; amounts of M or more clear the word.
    assign b_big_c = (B >= M'(M));

    mux_2NtoN #(
        .M (M)
    ) u_mux (
        .a   (shifted_c),
        .b   (A),
        .sel (load_c),
        .y_c (mux_y_c)
    );

    // Next-state, datapath and output computation.
    always_comb begin
        state_nxt = state_q;
        work_nxt  = work_q;
        cnt_nxt   = cnt_q;
        carry_nxt = carry_q;
        vlat_nxt  = vlat_q;
        r_nxt     = r_q;
        flags_nxt = flags_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    if (B == '0) begin
                        state_nxt   = DONE;
                        done_nxt    = 1'b1;
                        r_nxt       = A;
                        flags_nxt.c = 1'b0;
                        flags_nxt.n = A[M-1];
                        flags_nxt.v = 1'b0;
                        flags_nxt.z = (A == '0);
                    end else begin
                        state_nxt = SHIFT;
                        busy_nxt  = 1'b1;
                        work_nxt  = mux_y_c;
                        cnt_nxt   = b_big_c ? CW'(M) : CW'(B);
                        vlat_nxt  = b_big_c;
                        carry_nxt = 1'b0;
                    end
                end
            end

            SHIFT: begin
                work_nxt  = mux_y_c;
                carry_nxt = work_q[M-1];
                cnt_nxt   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    r_nxt       = mux_y_c;
                    flags_nxt.c = work_q[M-1];
                    flags_nxt.n = mux_y_c[M-1];
                    flags_nxt.v = vlat_q;
                    flags_nxt.z = (mux_y_c == '0);
                end else begin
                    busy_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            vlat_q  <= 1'b0;
            r_q     <= '0;
            flags_q <= FLAGS_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            work_q  <= work_nxt;
            cnt_q   <= cnt_nxt;
            carry_q <= carry_nxt;
            vlat_q  <= vlat_nxt;
            r_q     <= r_nxt;
            flags_q <= flags_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign C    = flags_q.c;
    assign N    = flags_q.n;
    assign V    = flags_q.v;
    assign Z    = flags_q.z;

endmodule

// File: tb/tb_shiftl_seq.sv
// Scoreboard bench for shiftl_seq (M=4): driver pushes expected results from
// an arithmetic model, a negedge monitor pops and compares on every done.
module tb_shiftl_seq;

    localparam int unsigned M = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         busy;
    logic         done;
    logic [M-1:0] R;
    logic         C;
    logic         N;
    logic         V;
    logic         Z;

    shiftl_seq #(.M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .C     (C),
        .N     (N),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M-1:0] r;
        logic         c;
        logic         n;
        logic         v;
        logic         z;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint got, input longint expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Reference: shift as integer arithmetic; carry is the bit that lands at position M.
    function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b,
                                   input int k, input string tag);
        exp_t e;
        int   sh;
        int   w;
        sh    = (int'(b) >= M) ? M : int'(b);
        w     = int'(a) << sh;
        e.r   = M'(w % (1 << M));
        e.c   = (sh == 0) ? 1'b0 : 1'((w >> M) & 1);
        e.v   = (int'(b) >= M);
        e.n   = e.r[M-1];
        e.z   = (e.r == '0);
        e.cyc = k + 1 + sh;
        e.tag = tag;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                me = q.pop_front();
                check({me.tag, " R"}, R, me.r);
                check({me.tag, " CNVZ"}, {C, N, V, Z}, {me.c, me.n, me.v, me.z});
                check({me.tag, " done_cycle"}, cyc, me.cyc);
                check({me.tag, " busy_at_done"}, busy, 0);
            end
        end
    end

    // Issue one operation and wait for its done; now=1 drives in the current (DONE) cycle.
    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b,
                          input bit now, input bit inject, input string tag);
        int sh;
        int bc;
        bit seen;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        A     = a;
        B     = b;
        start = 1'b1;
        sh    = (int'(b) >= M) ? M : int'(b);
        q.push_back(model(a, b, cyc, tag));
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                start = 1'b0;
                A     = M'($urandom);
                B     = M'($urandom);
            end
            if (inject && i == 0) begin
                start = 1'b1;
                A     = 4'b1111;
                B     = 4'b0001;
            end
            if (inject && i == 1) start = 1'b0;
            if (busy) bc++;
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " busy_cycles"}, bc, sh);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, R, C, N, V, Z}, {1'b0, 1'b0, 4'b0000, 4'b0001});
        rst = 1'b0;

        run_op(4'b1011, 4'd1, 1'b0, 1'b0, "b1");
        run_op(4'b1011, 4'd2, 1'b0, 1'b0, "b2");
        run_op(4'b1000, 4'd0, 1'b0, 1'b0, "b0");
        run_op(4'b0001, 4'd9, 1'b0, 1'b0, "b9");
        run_op(4'b0011, 4'd3, 1'b0, 1'b1, "ignored_start");
        run_op(4'b1111, 4'd4, 1'b0, 1'b0, "b_eq_m");
        run_op(4'b0000, 4'd0, 1'b0, 1'b0, "zero_b0");

        // Reset in the middle of a B=3 shift: no done, outputs return to reset values.
        @(posedge clk);
        #1;
        A     = 4'b0110;
        B     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midop_reset_outputs", {busy, done, R, C, N, V, Z}, {1'b0, 1'b0, 4'b0000, 4'b0001});
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_idle", {busy, done, R, Z}, {1'b0, 1'b0, 4'b0000, 1'b1});

        // Back-to-back: second start in the DONE cycle of the first.
        run_op(4'b1001, 4'd3, 1'b0, 1'b0, "b2b_first");
        run_op(4'b0101, 4'd1, 1'b1, 1'b0, "b2b_second");

        for (int t = 0; t < 40; t++) begin
            run_op(M'($urandom), M'($urandom_range(0, 15)), 1'(($urandom % 3) == 0), 1'b0, "rand");
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
